// File: rtl/mem_arbiter.sv
//==============================================================================
// Module      : mem_arbiter
// Description : Round-robin two-requester arbiter and sequencer for a single
//               memory port, with a bounded acknowledge timeout.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              req0_done,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              req1_done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              sel,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam logic [7:0] c_WAIT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_last;
    logic                r_sel;
    logic [7:0]          r_wait_cnt;
    logic                r_cmd_we;
    logic [ADDR_W-1:0]   r_cmd_addr;
    logic [DATA_W-1:0]   r_cmd_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_done0;
    logic                r_done1;
    logic                r_err;

    logic                w_gnt0;
    logic                w_gnt1;
    logic                w_in_access;
    logic                w_timeout;

    // rst_n gates the grants so ready stays low while reset is held.
    always_comb begin
        w_in_access = (r_state == ST_ACCESS);
        w_gnt0      = !w_in_access && rst_n && req0_valid && (!req1_valid || r_last);
        w_gnt1      = !w_in_access && rst_n && req1_valid && (!req0_valid || !r_last);
        w_timeout   = (r_wait_cnt == c_WAIT_LAST);
    end

    always_comb begin
        w_state_nxt = r_state;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req0_ready = w_gnt0;
                req1_ready = w_gnt1;
                if (w_gnt0 || w_gnt1) begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_en = 1'b1;
                mem_we = r_cmd_we;
                if (mem_ack || w_timeout) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last      <= 1'b1;
            r_sel       <= 1'b0;
            r_wait_cnt  <= 8'd0;
            r_cmd_we    <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
            r_rdata     <= '0;
            r_done0     <= 1'b0;
            r_done1     <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_err   <= 1'b0;
            if (w_gnt0 || w_gnt1) begin
                r_cmd_we    <= w_gnt1 ? req1_we    : req0_we;
                r_cmd_addr  <= w_gnt1 ? req1_addr  : req0_addr;
                r_cmd_wdata <= w_gnt1 ? req1_wdata : req0_wdata;
                r_sel       <= w_gnt1;
                r_last      <= w_gnt1;
                r_wait_cnt  <= 8'd0;
            end
            if (w_in_access) begin
                if (mem_ack || w_timeout) begin
                    r_rdata <= mem_ack ? mem_rdata : '0;
                    r_err   <= !mem_ack;
                    r_done0 <= !r_sel;
                    r_done1 <= r_sel;
                end else begin
                    r_wait_cnt <= r_wait_cnt + 8'd1;
                end
            end
        end
    end

    assign req0_done = r_done0;
    assign req1_done = r_done1;
    assign err       = r_err;
    assign rdata     = r_rdata;
    assign sel       = r_sel;
    assign mem_addr  = r_cmd_addr;
    assign mem_wdata = r_cmd_wdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
//==============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid, req0_we, req1_valid, req1_we;
    logic [7:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
    logic       req0_ready, req0_done, req1_ready, req1_done;
    logic       err, sel, mem_en, mem_we, mem_ack;
    logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_W(8), .ADDR_W(8), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_done(req0_done),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_done(req1_done),
        .err(err), .rdata(rdata), .sel(sel),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    task automatic clear_inputs();
        req0_valid = 0; req0_we = 0; req0_addr = 0; req0_wdata = 0;
        req1_valid = 0; req1_we = 0; req1_addr = 0; req1_wdata = 0;
        mem_ack = 0; mem_rdata = 0;
    endtask

    // Advance to the next negedge, where inputs are driven and outputs sampled.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [39:0] outs;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            {req0_valid, req0_we, req1_valid, req1_we, mem_ack} = 5'($urandom);
            req0_addr = 8'($urandom); req1_addr = 8'($urandom);
            req0_wdata = 8'($urandom); req1_wdata = 8'($urandom);
            mem_rdata = 8'($urandom);
            #1;
            outs = {req0_ready, req1_ready, req0_done, req1_done, err, sel,
                    mem_en, mem_we, rdata, mem_addr, mem_wdata, 8'h00};
            n_tests++;
            if (outs !== 40'h0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: got %h expected 0", i, outs);
            end
        end
        next_cycle();
        clear_inputs();
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            n_tests++;
            if ({mem_en, req0_done, req1_done} !== 3'b000) begin
                n_fail++;
                $display("FAIL idle_after_reset: mem_en/done got %b expected 000",
                         {mem_en, req0_done, req1_done});
            end
        end
    endtask

    task automatic test_single_read();
        next_cycle();
        req0_valid = 1; req0_we = 0; req0_addr = 8'h3C; #1;
        n_tests++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL read_ready: got %b%b expected 10", req0_ready, req1_ready);
        end
        next_cycle();
        req0_valid = 0; req0_addr = 8'h00; #1;
        n_tests++;
        if (mem_en !== 1'b1 || mem_addr !== 8'h3C || mem_we !== 1'b0 || req0_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL read_t1: en=%b addr=%h we=%b rdy=%b expected 1 3c 0 0",
                     mem_en, mem_addr, mem_we, req0_ready);
        end
        next_cycle();
        mem_ack = 1; mem_rdata = 8'hA5; #1;
        n_tests++;
        if (mem_en !== 1'b1 || mem_addr !== 8'h3C || req0_done !== 1'b0) begin
            n_fail++;
            $display("FAIL read_t2: en=%b addr=%h done=%b expected 1 3c 0",
                     mem_en, mem_addr, req0_done);
        end
        next_cycle();
        mem_ack = 0; mem_rdata = 8'h00; #1;
        n_tests++;
        if (req0_done !== 1'b1 || req1_done !== 1'b0 || rdata !== 8'hA5 || err !== 1'b0 || mem_en !== 1'b0) begin
            n_fail++;
            $display("FAIL read_done: done0=%b done1=%b rdata=%h err=%b en=%b expected 1 0 a5 0 0",
                     req0_done, req1_done, rdata, err, mem_en);
        end
    endtask

    task automatic test_single_write();
        next_cycle();
        req1_valid = 1; req1_we = 1; req1_addr = 8'h10; req1_wdata = 8'h7E; #1;
        n_tests++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL write_ready: got %b%b expected 01", req0_ready, req1_ready);
        end
        next_cycle();
        clear_inputs();
        mem_ack = 1; #1;
        n_tests++;
        if (sel !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h10 || mem_wdata !== 8'h7E) begin
            n_fail++;
            $display("FAIL write_t1: sel=%b en=%b we=%b addr=%h wdata=%h expected 1 1 1 10 7e",
                     sel, mem_en, mem_we, mem_addr, mem_wdata);
        end
        next_cycle();
        mem_ack = 0; #1;
        n_tests++;
        if (req1_done !== 1'b1 || req0_done !== 1'b0 || err !== 1'b0 || mem_we !== 1'b0 || sel !== 1'b1) begin
            n_fail++;
            $display("FAIL write_done: done1=%b done0=%b err=%b we=%b sel=%b expected 1 0 0 0 1",
                     req1_done, req0_done, err, mem_we, sel);
        end
    endtask

    // last == 1 after the write, so grants must run 0,1,0,1,0,1.
    task automatic test_back_to_back();
        logic exp_req;
        next_cycle();
        req0_valid = 1; req0_addr = 8'h20; req1_valid = 1; req1_addr = 8'h30;
        mem_ack = 1; mem_rdata = 8'h11;
        for (int i = 0; i < 12; i++) begin
            if (i != 0) next_cycle();
            #1;
            exp_req = 1'((i / 2) % 2);
            if (i % 2 == 0) begin
                n_tests++;
                if (req0_ready !== !exp_req || req1_ready !== exp_req) begin
                    n_fail++;
                    $display("FAIL contention_grant %0d: ready=%b%b expected %b%b",
                             i / 2, req0_ready, req1_ready, !exp_req, exp_req);
                end
                if (i > 0) begin
                    n_tests++;
                    if (req0_done !== exp_req || req1_done !== !exp_req) begin
                        n_fail++;
                        $display("FAIL contention_done %0d: done=%b%b expected %b%b",
                                 i / 2, req0_done, req1_done, exp_req, !exp_req);
                    end
                end
            end else begin
                n_tests++;
                if (mem_en !== 1'b1 || sel !== exp_req || mem_addr !== (exp_req ? 8'h30 : 8'h20)) begin
                    n_fail++;
                    $display("FAIL contention_access %0d: en=%b sel=%b addr=%h expected sel %b",
                             i / 2, mem_en, sel, mem_addr, exp_req);
                end
            end
        end
        next_cycle();
        clear_inputs(); #1;
        n_tests++;
        if (req1_done !== 1'b1 || req0_done !== 1'b0 || mem_en !== 1'b0) begin
            n_fail++;
            $display("FAIL contention_last_done: done=%b%b en=%b expected 01 0",
                     req0_done, req1_done, mem_en);
        end
    endtask

    task automatic test_timeout();
        next_cycle();
        req0_valid = 1; req0_we = 0; req0_addr = 8'h44; #1;
        n_tests++;
        if (req0_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_ready: got %b expected 1", req0_ready);
        end
        next_cycle();
        req0_valid = 0;
        for (int i = 1; i <= 15; i++) begin
            if (i != 1) next_cycle();
            #1;
            n_tests++;
            if (mem_en !== 1'b1 || req0_done !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_wait %0d: en=%b done=%b expected 1 0", i, mem_en, req0_done);
            end
        end
        next_cycle(); #1;
        n_tests++;
        if (req0_done !== 1'b1 || err !== 1'b1 || rdata !== 8'h00 || mem_en !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_done: done=%b err=%b rdata=%h en=%b expected 1 1 00 0",
                     req0_done, err, rdata, mem_en);
        end
        next_cycle();
        req1_valid = 1; req1_we = 0; req1_addr = 8'h55; #1;
        n_tests++;
        if (req1_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL after_timeout_ready: got %b expected 1", req1_ready);
        end
        next_cycle();
        clear_inputs();
        mem_ack = 1; mem_rdata = 8'h5A;
        next_cycle();
        clear_inputs(); #1;
        n_tests++;
        if (req1_done !== 1'b1 || err !== 1'b0 || rdata !== 8'h5A) begin
            n_fail++;
            $display("FAIL after_timeout_done: done=%b err=%b rdata=%h expected 1 0 5a",
                     req1_done, err, rdata);
        end
    endtask

    task automatic test_reset_mid_access();
        next_cycle();
        req1_valid = 1; req1_we = 1; req1_addr = 8'h66; req1_wdata = 8'h99;
        next_cycle();
        clear_inputs(); #1;
        n_tests++;
        if (mem_en !== 1'b1 || sel !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_pre: en=%b sel=%b expected 1 1", mem_en, sel);
        end
        #1 rst_n = 0; #1;
        n_tests++;
        if ({mem_en, mem_we, sel, mem_addr, mem_wdata, rdata} !== 27'h0) begin
            n_fail++;
            $display("FAIL midreset_async: en=%b we=%b sel=%b addr=%h wdata=%h expected all 0",
                     mem_en, mem_we, sel, mem_addr, mem_wdata);
        end
        mem_ack = 1;
        next_cycle();
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            next_cycle(); #1;
            n_tests++;
            if ({req0_done, req1_done, mem_en} !== 3'b000) begin
                n_fail++;
                $display("FAIL midreset_no_done %0d: done=%b%b en=%b expected 000",
                         i, req0_done, req1_done, mem_en);
            end
        end
        next_cycle();
        req0_valid = 1; req1_valid = 1; #1;
        n_tests++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_first_grant: ready=%b%b expected 10", req0_ready, req1_ready);
        end
        next_cycle();
        clear_inputs();
        next_cycle();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_read();
        test_single_write();
        test_back_to_back();
        test_timeout();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the single 8-bit memory port of the NRISC core. Requester 0 is instruction fetch and requester 1 is load/store. The block grants the port round-robin and latches the winner's command. It drives the 2:1 address/data mux select and the memory strobe, then returns read data with a one-cycle done pulse. A bounded wait counter aborts accesses that the memory never acknowledges.

## Interface
- `DATA_W`, default 8: data width.
- `ADDR_W`, default 8: address width.
- `TIMEOUT`, default 15: maximum ACCESS cycles without `mem_ack` before abort (range 1–255).

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid`, `req1_valid`  in  1  requester has a command pending.
- `req0_we`, `req1_we`  in  1  command is a write (1) or a read (0).
- `req0_addr`, `req1_addr`  in  ADDR_W  command address.
- `req0_wdata`, `req1_wdata`  in  DATA_W  write data.
- `req0_ready`, `req1_ready`  out  1  command accepted this cycle; combinational.
- `req0_done`, `req1_done`  out  1  access finished; registered one-cycle pulse.
- `err`  out  1  the finishing access timed out; asserted together with the done pulse.
- `rdata`  out  DATA_W  read data, valid while a done pulse is high.
- `sel`  out  1  mux select: 0 routes requester 0, 1 routes requester 1.
- `mem_en`  out  1  memory strobe.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data, sampled when `mem_ack` is high.
- `mem_ack`  in  1  memory completed the access this cycle.

## Operation
**States:** IDLE and ACCESS.

**IDLE**
- Arbitration:
  - Only one `reqN_valid` high: grant N.
  - Both high: grant the requester that is not `last`.
  - Neither high: stay in IDLE.
- On a grant:
  - `reqN_ready` = 1 in the same cycle; the transfer happens on `valid & ready`.
  - Latch `we`, `addr` and `wdata` from the winner.
  - Set `sel` and `last` to N.
  - Clear `wait_cnt` to 0.
  - Go to ACCESS.
- `reqN_ready` is 0 in every state except IDLE.

**ACCESS**
- Outputs:
  - `mem_en` = 1.
  - `mem_we`, `mem_addr` and `mem_wdata` come from the latched command.
  - Requester inputs are ignored and may change freely.
- Exit conditions:
  - `mem_ack` = 1: register `rdata` = `mem_rdata`, pulse `done[sel]` next cycle with `err` = 0, go to IDLE.
  - `mem_ack` = 0 and `wait_cnt` == `TIMEOUT`-1: pulse `done[sel]` next cycle with `err` = 1, set `rdata` = 0, go to IDLE.
  - Otherwise: increment `wait_cnt` by 1.
- On writes `rdata` is don't-care; the bench must not check it.

**Overlap and arbitration rules**
- The done cycle is an IDLE cycle, so a new grant may happen in that same cycle.
- A requester whose valid stays high can be re-granted in its own done cycle, provided the other requester is idle.
- `sel` holds its last value while in IDLE.
- `wait_cnt` is 8 bits wide and never wraps, because it is bounded by `TIMEOUT`.
- Fairness: under continuous contention grants strictly alternate, so neither requester waits more than one access.

## Timing
- Reset values:
  - `state` = IDLE, `last` = 1 (first contended grant goes to requester 0).
  - `sel` = 0, `wait_cnt` = 0, latched command = 0.
  - All outputs 0, including `mem_*`, `rdata`, `done` and `err`.
- Latency: grant in cycle T; `mem_en` high from T+1; `mem_ack` arrives in cycle T+k (k ≥ 1); done and `rdata` appear in T+k+1.
- Minimum turnaround is 2 cycles per access, so back-to-back throughput is one access every 2 cycles with a zero-wait memory.
- Timeout: `mem_en` is high for exactly `TIMEOUT` cycles; the done/err pulse follows in the next cycle.
- `mem_ack` is ignored outside ACCESS.
- Reset mid-access: an asynchronous `rst_n` low returns everything to the reset values immediately. The in-flight access produces no done pulse.

## Test plan
- **Reset:** hold `rst_n` = 0 with random inputs. All outputs must stay 0. After release with no requests, stay in IDLE with `mem_en` = 0.
- **Single read:** `req0_valid` = 1, `addr` = 0x3C, read; memory acks 2 cycles after `mem_en` with `mem_rdata` = 0xA5. Required:
  - `req0_ready` in cycle T.
  - `mem_en` in T+1 and T+2, with `mem_addr` = 0x3C.
  - `req0_done` = 1, `rdata` = 0xA5, `err` = 0 in T+3.
- **Single write:** `req1` writes 0x7E to 0x10 with a zero-wait memory. Required: `sel` = 1; `mem_we` = 1 and `mem_wdata` = 0x7E for one cycle; `req1_done` in T+2.
- **Contention:** both valids held high for 6 accesses with a zero-wait memory. Grants must run 0,1,0,1,0,1 with one done pulse every 2 cycles.
- **Timeout:** `TIMEOUT` = 15 and `mem_ack` never asserted. Required: `mem_en` high for 15 cycles, then `req0_done` = 1, `err` = 1, `rdata` = 0; a following request is still served normally.
- **Reset mid-access:** pull `rst_n` low during ACCESS. Required: outputs go to 0 asynchronously and no done pulse follows. After release, a contended request is granted to requester 0.
